// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: timekeeping and time-setting controller for the watch.
// RUN counts real time (centiseconds through hours) from the system clock.
// Edit mode (SET_HOUR / SET_MIN / SET_SEC) freezes time. Button pulses pick
// a field and step it up or down, wrapping within that field only.
// Optional feature macro: CLOCK_BLINK_EN. When defined, a blink timer drives
// o_blank while editing. When undefined, o_blank is constant 0.
module clock_set_ctrl #(
  parameter int FCOUNT      = 1_000_000,
  parameter int BLINK_COUNT = 25_000_000,
  parameter int RST_HOUR    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       o_edit,
  output logic [1:0] o_field,
  output logic       o_blank
);

  // The state encoding is chosen to equal the o_field encoding.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] prescaler;
  logic          edit_d;
  logic [1:0]    field_d;

  // Resolve button priority once: mode > sel > up/down.
  // Pressing up and down together cancels out.
  logic mode_evt;
  logic sel_evt;
  logic up_evt;
  logic down_evt;
  logic in_edit;
  logic tick;

  assign mode_evt = btn_mode;
  assign sel_evt  = !btn_mode && btn_sel;
  assign up_evt   = !btn_mode && !btn_sel && btn_up && !btn_down;
  assign down_evt = !btn_mode && !btn_sel && btn_down && !btn_up;
  assign in_edit  = (state != RUN);
  assign tick     = (prescaler == PW'(FCOUNT - 1));

  // Step a value by +/-1 and wrap within 0..top.
  function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                           input logic [5:0] top,
                                           input logic       up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    // Other flops that sample it in the same edge then see the old value.
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Next-state logic: mode toggles edit. sel rotates the field in edit.
  always_comb begin
    // NOTE: the default assignment comes first, so every path assigns a value
    // and no latch is inferred.
    next_state = state;
    if (mode_evt) begin
      next_state = (state == RUN) ? SET_HOUR : RUN;
    end else if (sel_evt) begin
      case (state)
        SET_HOUR: next_state = SET_MIN;
        SET_MIN:  next_state = SET_SEC;
        SET_SEC:  next_state = SET_HOUR;
        default:  next_state = RUN;
      endcase
    end
  end

  // Output decode: compute the edit status and field from the next state.
  always_comb begin
    edit_d  = (next_state != RUN);
    field_d = next_state;
  end

  // Register the status outputs so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_edit  <= 1'b0;
      o_field <= 2'b00;
    end else begin
      o_edit  <= edit_d;
      o_field <= field_d;
    end
  end

  // Time datapath: prescaler, tick carry chain, and field edits.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      msec      <= '0;
      sec       <= '0;
      min       <= '0;
      hour      <= 5'(RST_HOUR);
    end else if (!in_edit) begin
      if (mode_evt) begin
        msec      <= '0;
        prescaler <= '0;
      end else if (tick) begin
        prescaler <= '0;
        // The whole carry chain settles on this one edge.
        if (msec == 7'd99) begin
          msec <= '0;
          if (sec == 6'd59) begin
            sec <= '0;
            if (min == 6'd59) begin
              min  <= '0;
              hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end else begin
          msec <= msec + 7'd1;
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end else begin
      // Time is frozen while editing. The prescaler is held at 0, so the
      // first tick after leaving edit lands FCOUNT cycles later.
      prescaler <= '0;
      if (mode_evt) begin
        msec <= '0;
      end else if (up_evt || down_evt) begin
        case (state)
          SET_HOUR: hour <= 5'(step_wrap({1'b0, hour}, 6'd23, up_evt));
          SET_MIN:  min  <= step_wrap(min, 6'd59, up_evt);
          SET_SEC:  sec  <= step_wrap(sec, 6'd59, up_evt);
          default:  ;
        endcase
      end
    end
  end

`ifdef CLOCK_BLINK_EN
  localparam int BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  logic [BW-1:0] blink_cnt;
  logic          edit_action;

  // A press that actually edits restarts the blink period, so the new
  // value is visible right away.
  assign edit_action = in_edit && (sel_evt || up_evt || down_evt);

  // Blink timer: runs only while editing, and restarts on entry or on a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      o_blank   <= 1'b0;
    end else if (!in_edit || next_state == RUN || edit_action) begin
      blink_cnt <= '0;
      o_blank   <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_COUNT - 1)) begin
      blink_cnt <= '0;
      o_blank   <= !o_blank;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_COUNT;
  assign o_blank      = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: randomized plus directed bench for clock_set_ctrl.
// The reference model keeps time as centiseconds-of-day and edits fields by
// decomposing that value. A per-cycle compare process checks every output.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

  localparam int FCOUNT      = 4;
  localparam int BLINK_COUNT = 8;
  localparam int RST_HOUR    = 12;
  localparam int DAY         = 24 * 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       o_edit;
  logic [1:0] o_field;
  logic       o_blank;

  clock_set_ctrl #(
    .FCOUNT(FCOUNT),
    .BLINK_COUNT(BLINK_COUNT),
    .RST_HOUR(RST_HOUR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_sel(btn_sel),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .msec(msec),
    .sec(sec),
    .min(min),
    .hour(hour),
    .o_edit(o_edit),
    .o_field(o_field),
    .o_blank(o_blank)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  // Model: t = centiseconds of the day; mode 0 = run, 1/2/3 = hour/min/sec.
  int m_t;
  int m_mode;
  int m_pre;
  int m_elapsed;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int e_msec();  return m_t % 100;               endfunction
  function automatic int e_sec();   return (m_t / 100) % 60;        endfunction
  function automatic int e_min();   return (m_t / 6000) % 60;       endfunction
  function automatic int e_hour();  return m_t / 360000;            endfunction
  function automatic int e_blank();
`ifdef CLOCK_BLINK_EN
    return (m_mode != 0) ? ((m_elapsed / BLINK_COUNT) % 2) : 0;
`else
    return 0;
`endif
  endfunction

  // Advance the model by one clock edge, given the inputs sampled at that edge.
  task automatic model_step(input bit r, input bit bm, input bit bs,
                            input bit bu, input bit bd);
    int h, mi, s, cs, d;
    bit acted;
    if (r) begin
      m_t = RST_HOUR * 360000; m_mode = 0; m_pre = 0; m_elapsed = 0;
      return;
    end
    if (bm) begin
      m_mode    = (m_mode == 0) ? 1 : 0;
      m_t       = m_t - (m_t % 100);
      m_pre     = 0;
      m_elapsed = 0;
    end else if (m_mode == 0) begin
      m_pre++;
      if (m_pre == FCOUNT) begin
        m_pre = 0;
        m_t   = (m_t + 1) % DAY;
      end
    end else begin
      m_pre = 0;
      acted = 1'b0;
      if (bs) begin
        m_mode = (m_mode % 3) + 1;
        acted  = 1'b1;
      end else if (bu != bd) begin
        acted = 1'b1;
        d  = bu ? 1 : -1;
        h  = e_hour(); mi = e_min(); s = e_sec(); cs = e_msec();
        if (m_mode == 1)      h  = (h + d + 24) % 24;
        else if (m_mode == 2) mi = (mi + d + 60) % 60;
        else                  s  = (s + d + 60) % 60;
        m_t = ((h * 60 + mi) * 60 + s) * 100 + cs;
      end
      if (acted) m_elapsed = 0;
      else       m_elapsed++;
    end
  endtask

  task automatic step(input bit bm, input bit bs, input bit bu, input bit bd);
    btn_mode = bm; btn_sel = bs; btn_up = bu; btn_down = bd;
    @(posedge clk);
    model_step(rst, bm, bs, bu, bd);
    #1;
    btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_time(input string tag, input int h, input int mi,
                            input int s, input int cs);
    check({tag, ".hour"}, int'(hour), h);
    check({tag, ".min"},  int'(min),  mi);
    check({tag, ".sec"},  int'(sec),  s);
    check({tag, ".msec"}, int'(msec), cs);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("msec",    int'(msec),    e_msec());
      check("sec",     int'(sec),     e_sec());
      check("min",     int'(min),     e_min());
      check("hour",    int'(hour),    e_hour());
      check("o_edit",  int'(o_edit),  (m_mode != 0) ? 1 : 0);
      check("o_field", int'(o_field), m_mode);
      check("o_blank", int'(o_blank), e_blank());
    end
  end

  initial begin
    m_t = 0; m_mode = 0; m_pre = 0; m_elapsed = 0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_time("reset", 12, 0, 0, 0);
    check("reset.o_edit", int'(o_edit), 0);
    check("reset.o_field", int'(o_field), 0);

    // 400 clocks = 100 ticks: msec wrap and sec carry land on the same edge.
    idle(399);
    check_time("run399", 12, 0, 0, 99);
    idle(1);
    check_time("run400", 12, 0, 1, 0);

    // Run briefly so msec is nonzero, then enter edit and step hour down.
    idle(13);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("enter.o_edit", int'(o_edit), 1);
    check("enter.o_field", int'(o_field), 1);
    check("enter.msec", int'(msec), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("hour_down", int'(hour), 11);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("sel_min.o_field", int'(o_field), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_time("min_borrowless", 11, 59, 1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("sel_sec.o_field", int'(o_field), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sec_wrap_down", int'(sec), 59);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_time("sec_wrap_up", 11, 59, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("sel_wrap.o_field", int'(o_field), 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("hour_to_23", int'(hour), 23);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    // mode wins over up in the same cycle.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("mode_up.o_edit", int'(o_edit), 0);
    check_time("mode_up", 23, 59, 59, 0);

    // Midnight rollover: 99 ticks, then one more tick clears everything.
    idle(396);
    check_time("pre_midnight", 23, 59, 59, 99);
    idle(4);
    check_time("midnight", 0, 0, 0, 0);

    // In edit, up and down together leave the field alone.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("updown_hold", int'(hour), 0);

`ifdef CLOCK_BLINK_EN
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(7);
    check("blink_low", int'(o_blank), 0);
    idle(1);
    check("blink_high", int'(o_blank), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_press", int'(o_blank), 0);
`endif

    // Randomized phase: sparse button pulses, checked each cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    // Reset while editing returns everything to the reset values.
    if (m_mode == 0) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check_time("rst_edit", 12, 0, 0, 0);
    check("rst_edit.o_edit", int'(o_edit), 0);
    check("rst_edit.o_field", int'(o_field), 0);
    check("rst_edit.o_blank", int'(o_blank), 0);
    idle(5);

    @(posedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
